// File: rtl/pb_mesh_link_pkg.sv
// Shared types and helpers for the pb_mesh_link NoC link stage.
//   link_state_e : isolation FSM states (ACTIVE, DRAIN, FLUSH, ISOLATED)
//   cnt_w()      : width of a counter that must hold the value 0..depth
//   Default*     : default payload width (wide flit) and FIFO depth
package pb_mesh_link_pkg;

  typedef enum logic [1:0] {
    ACTIVE   = 2'd0,
    DRAIN    = 2'd1,
    FLUSH    = 2'd2,
    ISOLATED = 2'd3
  } link_state_e;

  // Widest floo flit (wide channel); req/rsp channels zero-pad into it.
  localparam int DefaultDataWidth = 512;
  localparam int DefaultDepth     = 2;

  // Bits needed to represent 0..depth inclusive (never less than 1).
  function automatic int cnt_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pb_link_fifo.sv
// Single-channel FIFO used by pb_mesh_link.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   flush_i         synchronous discard of all entries
//   push_i, data_i  write one entry (caller guarantees not full)
//   pop_i           drop the head entry (caller guarantees not empty)
//   data_o          head entry, stable until popped
//   count_o         number of stored entries (0..Depth)
// Pointers wrap modulo Depth, so Depth need not be a power of two.
module pb_link_fifo
  import pb_mesh_link_pkg::*;
#(
  parameter int DataWidth = DefaultDataWidth,
  parameter int Depth     = DefaultDepth
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [DataWidth-1:0]     data_i,
  input  logic                     pop_i,
  output logic [DataWidth-1:0]     data_o,
  output logic [cnt_w(Depth)-1:0]  count_o
);

  localparam int CntW = cnt_w(Depth);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  // Storage is sized to the pointer range so every pointer value indexes a
  // real slot; slots at or above Depth are never written.
  localparam int MemN = 2 ** PtrW;

  logic [DataWidth-1:0] mem [MemN];
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      rd_ptr;
  logic [CntW-1:0]      count_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Payload storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_i)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem[rd_ptr];
  assign count_o = count_q;

endmodule

// File: rtl/pb_mesh_link.sv
// Inter-tile mesh link stage: NumChan independent valid/ready channels, each
// buffered in its own pb_link_fifo, plus drain-then-block isolation with a
// bounded drain timeout.
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   in_valid_i/in_ready_o/in_data_i     upstream handshake and payload
//   out_valid_o/out_ready_i/out_data_o  downstream handshake and payload
//   isolate_i                     level request to isolate the link
//   isolated_o                    link isolated, nothing in flight
//   drain_err_o                   sticky: a drain timed out, flits discarded
//   clr_err_i                     clears drain_err_o (and perf counters)
// Optional build macro PB_MESH_LINK_PERF_EN adds per-channel saturating
// counters perf_flits_o (pops) and perf_stall_o (valid & !ready cycles).
module pb_mesh_link
  import pb_mesh_link_pkg::*;
#(
  parameter int NumChan        = 3,
  parameter int DataWidth      = DefaultDataWidth,
  parameter int Depth          = DefaultDepth,
  parameter int DrainTimeout   = 256,
  parameter int IsolateOnReset = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumChan-1:0]             in_valid_i,
  output logic [NumChan-1:0]             in_ready_o,
  input  logic [NumChan*DataWidth-1:0]   in_data_i,
  output logic [NumChan-1:0]             out_valid_o,
  input  logic [NumChan-1:0]             out_ready_i,
  output logic [NumChan*DataWidth-1:0]   out_data_o,
  input  logic                           isolate_i,
  output logic                           isolated_o,
  output logic                           drain_err_o,
  input  logic                           clr_err_i
`ifdef PB_MESH_LINK_PERF_EN
  ,
  output logic [NumChan*32-1:0]          perf_flits_o,
  output logic [NumChan*32-1:0]          perf_stall_o
`endif
);

  localparam int CntW   = cnt_w(Depth);
  localparam int DrainW = cnt_w(DrainTimeout);
  localparam link_state_e ResetState = (IsolateOnReset != 0) ? ISOLATED : ACTIVE;

  if (Depth < 1) begin : g_bad_depth
    $error("pb_mesh_link: Depth must be >= 1");
  end
  if (DrainTimeout < 1) begin : g_bad_timeout
    $error("pb_mesh_link: DrainTimeout must be >= 1");
  end

  link_state_e       state_q, state_d;
  logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
  logic              drain_err_q;
  logic              all_empty;
  logic              flush;
  logic [NumChan-1:0] push, pop;
  logic [CntW-1:0]   fifo_cnt [NumChan];

  assign flush = (state_q == FLUSH);

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    // Ready and valid decode only registered state and count; rst_i forces
    // ready low while reset is held.
    assign in_ready_o[c]  = ~rst_i & (state_q == ACTIVE) & (fifo_cnt[c] < CntW'(Depth));
    assign out_valid_o[c] = (fifo_cnt[c] != '0) & ((state_q == ACTIVE) | (state_q == DRAIN));
    assign push[c]        = in_valid_i[c] & in_ready_o[c];
    assign pop[c]         = out_valid_o[c] & out_ready_i[c];

    pb_link_fifo #(
      .DataWidth (DataWidth),
      .Depth     (Depth)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush),
      .push_i  (push[c]),
      .data_i  (in_data_i[c*DataWidth +: DataWidth]),
      .pop_i   (pop[c]),
      .data_o  (out_data_o[c*DataWidth +: DataWidth]),
      .count_o (fifo_cnt[c])
    );

`ifdef PB_MESH_LINK_PERF_EN
    logic [31:0] flits_q, stall_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        flits_q <= '0;
        stall_q <= '0;
      end else if (clr_err_i) begin
        flits_q <= '0;
        stall_q <= '0;
      end else begin
        if (pop[c] && (flits_q != '1)) flits_q <= flits_q + 32'd1;
        if (out_valid_o[c] && !out_ready_i[c] && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      end
    end
    assign perf_flits_o[c*32 +: 32] = flits_q;
    assign perf_stall_o[c*32 +: 32] = stall_q;
`endif
  end

  always_comb begin
    all_empty = 1'b1;
    for (int c = 0; c < NumChan; c++) begin
      if (fifo_cnt[c] != '0) all_empty = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ACTIVE: begin
        if (isolate_i) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        // Emptiness takes priority over a withdrawn request.
        if (all_empty)                                   state_d = ISOLATED;
        else if (!isolate_i)                             state_d = ACTIVE;
        else if (drain_cnt_q == DrainW'(DrainTimeout - 1)) state_d = FLUSH;
        else                                             drain_cnt_d = drain_cnt_q + DrainW'(1);
      end
      FLUSH:    state_d = ISOLATED;
      ISOLATED: if (!isolate_i) state_d = ACTIVE;
      default:  state_d = ResetState;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ResetState;
      drain_cnt_q <= '0;
      drain_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      // A flush in the same cycle as a clear still records the error.
      if (flush)          drain_err_q <= 1'b1;
      else if (clr_err_i) drain_err_q <= 1'b0;
    end
  end

  assign isolated_o  = (state_q == ISOLATED);
  assign drain_err_o = drain_err_q;

endmodule

// File: tb/tb_pb_mesh_link.sv
module tb_pb_mesh_link;

  localparam int NCH = 3;
  localparam int DW  = 16;
  localparam int DEP = 2;
  localparam int DTO = 8;

  localparam int M_ACT = 0;
  localparam int M_DRN = 1;
  localparam int M_FLS = 2;
  localparam int M_ISO = 3;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic [NCH-1:0]     in_valid_i;
  logic [NCH-1:0]     in_ready_o;
  logic [NCH*DW-1:0]  in_data_i;
  logic [NCH-1:0]     out_valid_o;
  logic [NCH-1:0]     out_ready_i;
  logic [NCH*DW-1:0]  out_data_o;
  logic               isolate_i;
  logic               isolated_o;
  logic               drain_err_o;
  logic               clr_err_i;
`ifdef PB_MESH_LINK_PERF_EN
  logic [NCH*32-1:0]  perf_flits_o;
  logic [NCH*32-1:0]  perf_stall_o;
`endif

  pb_mesh_link #(
    .NumChan(NCH), .DataWidth(DW), .Depth(DEP), .DrainTimeout(DTO), .IsolateOnReset(0)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .isolate_i   (isolate_i),
    .isolated_o  (isolated_o),
    .drain_err_o (drain_err_o),
    .clr_err_i   (clr_err_i)
`ifdef PB_MESH_LINK_PERF_EN
    ,
    .perf_flits_o(perf_flits_o),
    .perf_stall_o(perf_stall_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: per-channel queues, link mode, drain cycle count, error flag.
  logic [DW-1:0] mq [NCH][$];
  int            mode;
  int            dcyc;
  logic          merr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) mq[c].delete();
    mode = M_ACT;
    dcyc = 0;
    merr = 1'b0;
  endtask

  // Drive one cycle of inputs, compare current outputs to the model, advance
  // the model by one clock, then move to 1 time unit after the next edge.
  task automatic step(input logic [NCH-1:0] iv, input logic [NCH*DW-1:0] id,
                      input logic [NCH-1:0] ordy, input logic iso, input logic clr);
    logic [NCH-1:0] exp_ir, exp_ov;
    bit empty_now;
    in_valid_i  = iv;
    in_data_i   = id;
    out_ready_i = ordy;
    isolate_i   = iso;
    clr_err_i   = clr;
    empty_now   = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      exp_ir[c] = (mode == M_ACT) && (mq[c].size() < DEP);
      exp_ov[c] = ((mode == M_ACT) || (mode == M_DRN)) && (mq[c].size() != 0);
      if (mq[c].size() != 0) empty_now = 1'b0;
    end
    chk("in_ready", 64'(in_ready_o), 64'(exp_ir));
    chk("out_valid", 64'(out_valid_o), 64'(exp_ov));
    for (int c = 0; c < NCH; c++)
      if (exp_ov[c]) chk($sformatf("out_data_ch%0d", c), 64'(out_data_o[c*DW +: DW]), 64'(mq[c][0]));
    chk("isolated", 64'(isolated_o), 64'(mode == M_ISO));
    chk("drain_err", 64'(drain_err_o), 64'(merr));

    if (mode == M_FLS) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      merr = 1'b1;
      mode = M_ISO;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (exp_ov[c] && ordy[c]) void'(mq[c].pop_front());
        if (exp_ir[c] && iv[c])   mq[c].push_back(id[c*DW +: DW]);
      end
      if (clr) merr = 1'b0;
      if (mode == M_ACT) begin
        if (iso) begin mode = M_DRN; dcyc = 0; end
      end else if (mode == M_DRN) begin
        if (empty_now)            mode = M_ISO;
        else if (!iso)            mode = M_ACT;
        else if (dcyc == DTO - 1) mode = M_FLS;
        else                      dcyc++;
      end else if (mode == M_ISO) begin
        if (!iso) mode = M_ACT;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          rdy;
    logic          exp_ir;
    logic          exp_ov;
    logic [DW-1:0] exp_d;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic iso_r;
    // Table on ch0: 4-flit stream with ready high, then fill-to-full and release.
    tbl[0]  = '{1'b1, 16'h000A, 1'b1, 1'b1, 1'b0, 16'h0};
    tbl[1]  = '{1'b1, 16'h000B, 1'b1, 1'b1, 1'b1, 16'h000A};
    tbl[2]  = '{1'b1, 16'h000C, 1'b1, 1'b1, 1'b1, 16'h000B};
    tbl[3]  = '{1'b1, 16'h000D, 1'b1, 1'b1, 1'b1, 16'h000C};
    tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h000D};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0};
    tbl[6]  = '{1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0};
    tbl[7]  = '{1'b1, 16'h0002, 1'b0, 1'b1, 1'b1, 16'h0001};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0001};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0001};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0002};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0};

    rst_i = 1'b1; in_valid_i = '0; in_data_i = '0; out_ready_i = '0;
    isolate_i = 1'b0; clr_err_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_in_ready", 64'(in_ready_o), 64'(0));
    chk("rst_out_valid", 64'(out_valid_o), 64'(0));
    chk("rst_isolated", 64'(isolated_o), 64'(0));
    chk("rst_drain_err", 64'(drain_err_o), 64'(0));
    rst_i = 1'b0;
    #1;

    for (int i = 0; i < 12; i++) begin
      chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready_o[0]), 64'(tbl[i].exp_ir));
      chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid_o[0]), 64'(tbl[i].exp_ov));
      if (tbl[i].exp_ov)
        chk($sformatf("tbl%0d_out_data", i), 64'(out_data_o[DW-1:0]), 64'(tbl[i].exp_d));
      step({2'b00, tbl[i].v}, {32'h0, tbl[i].d}, {2'b11, tbl[i].rdy}, 1'b0, 1'b0);
    end

    // Clean drain: two flits on ch1, isolate with ready high.
    step(3'b010, {16'h0, 16'h1111, 16'h0}, 3'b000, 1'b0, 1'b0);
    step(3'b010, {16'h0, 16'h2222, 16'h0}, 3'b000, 1'b0, 1'b0);
    step(3'b000, '0, 3'b111, 1'b1, 1'b0);
    chk("drain_in_ready_low", 64'(in_ready_o), 64'(0));
    for (int k = 0; k < 10; k++) begin
      if (isolated_o) break;
      step(3'b000, '0, 3'b111, 1'b1, 1'b0);
    end
    chk("drain_reached_isolated", 64'(isolated_o), 64'(1));
    chk("drain_no_err", 64'(drain_err_o), 64'(0));
    chk("drain_outputs_idle", 64'(out_valid_o), 64'(0));
    step(3'b000, '0, 3'b111, 1'b0, 1'b0);

    // Drain timeout: one stuck flit on ch2.
    step(3'b100, {16'hBEEF, 32'h0}, 3'b000, 1'b0, 1'b0);
    step(3'b000, '0, 3'b000, 1'b1, 1'b0);
    for (int k = 0; k < DTO; k++) begin
      chk($sformatf("to_drain%0d_valid", k), 64'(out_valid_o[2]), 64'(1));
      step(3'b000, '0, 3'b000, 1'b1, 1'b0);
    end
    chk("to_flush_valid", 64'(out_valid_o), 64'(0));
    chk("to_flush_isolated", 64'(isolated_o), 64'(0));
    step(3'b000, '0, 3'b000, 1'b1, 1'b1);
    chk("to_err_set_wins", 64'(drain_err_o), 64'(1));
    chk("to_isolated", 64'(isolated_o), 64'(1));
    step(3'b000, '0, 3'b000, 1'b1, 1'b0);
    step(3'b000, '0, 3'b000, 1'b1, 1'b1);
    chk("to_err_cleared", 64'(drain_err_o), 64'(0));
    step(3'b000, '0, 3'b111, 1'b0, 1'b0);
    chk("to_flit_lost", 64'(out_valid_o), 64'(0));

    // Abort a drain: ch0 full, isolate for two cycles, then withdraw.
    step(3'b001, {32'h0, 16'h0055}, 3'b000, 1'b0, 1'b0);
    step(3'b001, {32'h0, 16'h0066}, 3'b000, 1'b0, 1'b0);
    step(3'b000, '0, 3'b000, 1'b1, 1'b0);
    step(3'b000, '0, 3'b000, 1'b1, 1'b0);
    step(3'b000, '0, 3'b000, 1'b0, 1'b0);
    chk("abort_ch1_ready", 64'(in_ready_o[1]), 64'(1));
    chk("abort_head", 64'(out_data_o[DW-1:0]), 64'(16'h0055));
    step(3'b000, '0, 3'b001, 1'b0, 1'b0);
    chk("abort_second", 64'(out_data_o[DW-1:0]), 64'(16'h0066));
    step(3'b000, '0, 3'b001, 1'b0, 1'b0);
    step(3'b000, '0, 3'b000, 1'b0, 1'b0);

    // Asynchronous reset with flits buffered.
    step(3'b011, {16'h0, 16'h0A0A, 16'h0B0B}, 3'b000, 1'b0, 1'b0);
    step(3'b011, {16'h0, 16'h0C0C, 16'h0D0D}, 3'b000, 1'b0, 1'b0);
    chk("pre_rst_valid", 64'(out_valid_o), 64'(3'b011));
    rst_i = 1'b1;
    #2;
    chk("async_rst_valid", 64'(out_valid_o), 64'(0));
    chk("async_rst_ready", 64'(in_ready_o), 64'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
    #1;
    chk("post_rst_ready", 64'(in_ready_o), 64'(3'b111));
    chk("post_rst_isolated", 64'(isolated_o), 64'(0));
    step(3'b000, '0, 3'b111, 1'b0, 1'b0);

    // Randomized traffic with occasional isolation and error clears.
    iso_r = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 24) == 0) iso_r = ~iso_r;
      step(NCH'($urandom), {NCH*DW{1'b0}} | {16'($urandom), 16'($urandom), 16'($urandom)},
           NCH'($urandom), iso_r, ($urandom_range(0, 39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
